// File: rtl/clkrecv_if.sv
`default_nettype none
// clkrecv_if: external clock input and recovered edge/measurement outputs of clkrecv.
// master = clock source / observer side, slave = clkrecv.
interface clkrecv_if #(
  parameter int CW = 7
);
  logic          sclk_i;
  logic          rise_o;
  logic          fall_o;
  logic          active_o;
  logic [CW-1:0] half_period_o;
  logic          glitch_o;
  logic          timeout_o;

  modport master (
    output sclk_i,
    input  rise_o, fall_o, active_o, half_period_o, glitch_o, timeout_o
  );

  modport slave (
    input  sclk_i,
    output rise_o, fall_o, active_o, half_period_o, glitch_o, timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/clkrecv.sv
`default_nettype none
// clkrecv: synchronizes a slow external clock, pulses on its edges, measures its half-period
// and flags timeouts. Macro CLKRECV_GLITCH_EN enables MIN_HALF glitch detection.
module clkrecv #(
  parameter int IDLE_HIGH   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HALF    = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  clkrecv_if.slave bus
);
  localparam int              CW         = $clog2(TIMEOUT + 1);
  localparam logic            c_IDLE_LVL = (IDLE_HIGH != 0);
  localparam logic [CW-1:0]   c_CNT_MAX  = CW'(TIMEOUT - 1);
`ifdef CLKRECV_GLITCH_EN
  localparam logic [CW-1:0]   c_MIN_HALF = CW'(MIN_HALF);
`endif

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("clkrecv: SYNC_STAGES must be at least 2");
  end
  if (MIN_HALF < 1) begin : g_bad_min_half
    $error("clkrecv: MIN_HALF must be at least 1");
  end
  if (TIMEOUT <= MIN_HALF) begin : g_bad_timeout
    $error("clkrecv: TIMEOUT must exceed MIN_HALF");
  end

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_edge;
  logic                   r_edge_lvl;
  logic                   w_edge;
  logic [CW-1:0]          w_meas;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_active;
  logic [CW-1:0]          r_half;
  logic                   r_glitch;
  logic                   r_timeout;

  assign w_edge = r_sync[SYNC_STAGES-1] ^ r_hist;
  assign w_meas = r_cnt + 1'b1;

  // Edge detect is registered once more so the FSM sees a clean single-cycle strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync     <= {SYNC_STAGES{c_IDLE_LVL}};
      r_hist     <= c_IDLE_LVL;
      r_edge     <= 1'b0;
      r_edge_lvl <= c_IDLE_LVL;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.sclk_i};
      r_hist     <= r_sync[SYNC_STAGES-1];
      r_edge     <= w_edge;
      r_edge_lvl <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_active  <= 1'b0;
      r_half    <= '0;
      r_glitch  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_rise    <= r_edge & r_edge_lvl;
      r_fall    <= r_edge & ~r_edge_lvl;
      r_glitch  <= 1'b0;
      r_timeout <= 1'b0;

      if (r_edge) begin
        r_cnt <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_edge) begin
            r_state  <= S_ACTIVE;
            r_active <= 1'b1;
          end
        end
        S_ACTIVE: begin
          // An edge on the saturation cycle wins over the timeout and measures TIMEOUT.
          if (r_edge) begin
`ifdef CLKRECV_GLITCH_EN
            if (w_meas < c_MIN_HALF) begin
              r_glitch <= 1'b1;
            end else begin
              r_half <= w_meas;
            end
`else
            r_half <= w_meas;
`endif
          end else if (r_cnt == c_CNT_MAX) begin
            r_state   <= S_IDLE;
            r_active  <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rise_o        = r_rise;
  assign bus.fall_o        = r_fall;
  assign bus.active_o      = r_active;
  assign bus.half_period_o = r_half;
  assign bus.glitch_o      = r_glitch;
  assign bus.timeout_o     = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_clkrecv.sv
`default_nettype none
`timescale 1ns/1ps
// tb_clkrecv: directed, table-driven checks of edge pulses, half-period measurement,
// glitch/timeout behaviour and asynchronous reset of clkrecv.
module tb_clkrecv;
  localparam int TO    = 64;
  localparam int CW    = 7;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
`ifdef CLKRECV_GLITCH_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_set = 0;

  clkrecv_if #(.CW(CW)) bus ();

  clkrecv #(
    .IDLE_HIGH  (1),
    .SYNC_STAGES(2),
    .MIN_HALF   (4),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial begin
    forever begin
      #5 clk_i = 1'b0;
      #5 begin
        cyc   = cyc + 1;
        clk_i = 1'b1;
      end
    end
  end

  logic          rec_rise [DEPTH];
  logic          rec_fall [DEPTH];
  logic          rec_gl   [DEPTH];
  logic          rec_to   [DEPTH];
  logic          rec_act  [DEPTH];
  logic [CW-1:0] rec_half [DEPTH];
  bit            exp_rise [DEPTH];
  bit            exp_fall [DEPTH];
  bit            exp_gl   [DEPTH];
  bit            exp_to   [DEPTH];

  always @(posedge clk_i) begin
    #1;
    if (cyc < DEPTH) begin
      rec_rise[cyc] <= bus.rise_o;
      rec_fall[cyc] <= bus.fall_o;
      rec_gl[cyc]   <= bus.glitch_o;
      rec_to[cyc]   <= bus.timeout_o;
      rec_act[cyc]  <= bus.active_o;
      rec_half[cyc] <= bus.half_period_o;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Set sclk_i right after a clock edge and hold it for 'hold' cycles; optionally
  // record where its edge pulse must appear.
  task automatic drv(input logic lvl, input int hold, input bit mark);
    @(posedge clk_i);
    #1;
    bus.sclk_i = lvl;
    last_set   = cyc;
    if (mark && (cyc + LAT < DEPTH)) begin
      if (lvl) exp_rise[cyc + LAT] = 1'b1;
      else     exp_fall[cyc + LAT] = 1'b1;
    end
    repeat (hold - 1) @(posedge clk_i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rise"},    int'(bus.rise_o),        0);
    chk({tag, ".fall"},    int'(bus.fall_o),        0);
    chk({tag, ".active"},  int'(bus.active_o),      0);
    chk({tag, ".half"},    int'(bus.half_period_o), 0);
    chk({tag, ".glitch"},  int'(bus.glitch_o),      0);
    chk({tag, ".timeout"}, int'(bus.timeout_o),     0);
  endtask

  typedef struct {
    logic lvl;
    int   hold;
    bit   gl;
    int   half_g;
    int   half_n;
  } vec_t;

  vec_t vecs[12];
  int   set_cyc[12];

  initial begin
    int p;
    int s1;
    int s3;
    int hp;

    vecs[0]  = '{1'b0, 4, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 4, 1'b0, 4, 4};
    vecs[2]  = '{1'b0, 4, 1'b0, 4, 4};
    vecs[3]  = '{1'b1, 4, 1'b0, 4, 4};
    vecs[4]  = '{1'b0, 4, 1'b0, 4, 4};
    vecs[5]  = '{1'b1, 4, 1'b0, 4, 4};
    vecs[6]  = '{1'b0, 2, 1'b0, 4, 4};
    vecs[7]  = '{1'b1, 4, 1'b1, 4, 2};
    vecs[8]  = '{1'b0, 5, 1'b0, 4, 4};
    vecs[9]  = '{1'b1, 6, 1'b0, 5, 5};
    vecs[10] = '{1'b0, 3, 1'b0, 6, 6};
    vecs[11] = '{1'b1, 4, 1'b1, 6, 3};

    bus.sclk_i = 1'b1;
    #2;
    chk_all_zero("reset_initial");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (6) @(posedge clk_i);

    // Burst, glitch pulse and varied half-periods
    for (int i = 0; i < 12; i++) begin
      drv(vecs[i].lvl, vecs[i].hold, 1'b1);
      set_cyc[i] = last_set;
      if (GEN && vecs[i].gl) exp_gl[last_set + LAT] = 1'b1;
    end

    // Timeout after the last edge
    p = set_cyc[11] + LAT;
    exp_to[p + TO] = 1'b1;
    repeat (TO + 12) @(posedge clk_i);
    #2;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec%0d.active", i), int'(rec_act[set_cyc[i] + LAT]), 1);
      chk($sformatf("vec%0d.half", i), int'(rec_half[set_cyc[i] + LAT]),
          GEN ? vecs[i].half_g : vecs[i].half_n);
    end
    hp = GEN ? 6 : 3;
    chk("to.active_before", int'(rec_act[p + TO - 1]), 1);
    chk("to.active_at",     int'(rec_act[p + TO]),     0);
    chk("to.half_at",       int'(rec_half[p + TO]),    hp);
    chk("to.active_after",  int'(rec_act[p + TO + 1]), 0);

    // Edge exactly TIMEOUT cycles after the previous edge pulse
    drv(1'b0, TO, 1'b1);
    s1 = last_set;
    drv(1'b1, 8, 1'b1);
    #2;
    chk("t64.enter_active", int'(rec_act[s1 + LAT]),          1);
    chk("t64.enter_half",   int'(rec_half[s1 + LAT]),         hp);
    chk("t64.active_pre",   int'(rec_act[s1 + LAT + TO - 1]), 1);
    chk("t64.active",       int'(rec_act[s1 + LAT + TO]),     1);
    chk("t64.half",         int'(rec_half[s1 + LAT + TO]),    TO);

    // Asynchronous reset mid-burst, pulse to the rise before it can appear
    drv(1'b0, 4, 1'b1);
    drv(1'b1, 2, 1'b0);
    #3;
    chk("pre_reset.active", int'(bus.active_o), 1);
    rst_ni = 1'b0;
    #1;
    chk_all_zero("reset_async");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(posedge clk_i);
    drv(1'b0, 8, 1'b1);
    s3 = last_set;
    repeat (4) @(posedge clk_i);
    #2;
    chk("post_reset.active", int'(rec_act[s3 + LAT]),  1);
    chk("post_reset.half",   int'(rec_half[s3 + LAT]), 0);

    // Cycle-by-cycle pulse expectations across the whole run
    for (int i = 1; i < cyc && i < DEPTH; i++) begin
      chk($sformatf("cyc%0d.rise", i),    int'(rec_rise[i]), int'(exp_rise[i]));
      chk($sformatf("cyc%0d.fall", i),    int'(rec_fall[i]), int'(exp_fall[i]));
      chk($sformatf("cyc%0d.glitch", i),  int'(rec_gl[i]),   int'(exp_gl[i]));
      chk($sformatf("cyc%0d.timeout", i), int'(rec_to[i]),   int'(exp_to[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/clkrecv.md
CLKRECV -- requirements
Module: clkrecv

Interface
REQ-001 Parameter IDLE_HIGH, default 1: the idle level of sclk_i is 1 when IDLE_HIGH=1 and 0 otherwise.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sclk_i; values below 2 SHALL force an elaboration failure.
REQ-003 Parameter MIN_HALF, default 4: minimum legal half-period in clk_i cycles; values below 1 SHALL fail elaboration.
REQ-004 Parameter TIMEOUT, default 64: clk_i cycles without an edge before the block returns to idle; TIMEOUT <= MIN_HALF SHALL fail elaboration.
REQ-005 Derived width CW = $clog2(TIMEOUT+1).
REQ-006 clk_i  input  1  system clock; the block SHALL have one clock and one reset, and reset is asynchronous and active-low.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 sclk_i  input  1  external low-speed clock (SPI/I2C-style), asynchronous to clk_i.
REQ-009 rise_o  output  1  one-cycle pulse per detected 0->1 transition of sclk_i.
REQ-010 fall_o  output  1  one-cycle pulse per detected 1->0 transition of sclk_i.
REQ-011 active_o  output  1  high while the state machine is in ACTIVE.
REQ-012 half_period_o  output  CW  last valid measured half-period, in clk_i cycles.
REQ-013 glitch_o  output  1  one-cycle pulse when a half-period shorter than MIN_HALF is measured.
REQ-014 timeout_o  output  1  one-cycle pulse on the ACTIVE->IDLE transition.

Function
REQ-015 sclk_i SHALL pass through SYNC_STAGES flops, then one history flop; an edge is detected when the synchronized level differs from the history flop.
REQ-016 All outputs SHALL be registered; a sclk_i change first sampled at clk_i edge k SHALL assert rise_o/fall_o during the cycle after clk_i edge k+SYNC_STAGES+1.
REQ-017 Edge counter cnt: cleared to 0 on a detected edge; otherwise it increments, saturating at TIMEOUT-1.
REQ-018 Measured half-period SHALL be cnt+1 at the edge cycle; for example, edges detected at cycles 10 and 14 give 4.
REQ-019 States SHALL be IDLE (reset) and ACTIVE.
REQ-020 In IDLE, any detected edge SHALL report rise_o/fall_o, enter ACTIVE and clear cnt, with no measurement, glitch or half_period_o update.
REQ-021 In ACTIVE, each detected edge SHALL report rise_o/fall_o and perform a measurement.
REQ-022 If the measurement is >= MIN_HALF, half_period_o SHALL update to that measurement; otherwise glitch_o SHALL pulse and half_period_o SHALL hold.
REQ-023 In ACTIVE, when cnt == TIMEOUT-1 and no edge is detected, the block SHALL go to IDLE and pulse timeout_o.
REQ-024 An edge in the same cycle as cnt == TIMEOUT-1 SHALL take priority: no timeout, the block stays in ACTIVE, and the measurement equals TIMEOUT.
REQ-025 half_period_o SHALL never exceed TIMEOUT and SHALL hold its value through IDLE.
REQ-026 rise_o and fall_o SHALL never be asserted in the same cycle.

Reset
REQ-027 While rst_ni=0: all synchronizer and history flops SHALL equal the idle level, state = IDLE, cnt = 0, and every output = 0.
REQ-028 After rst_ni deasserts with sclk_i at the idle level, no spurious rise_o or fall_o SHALL occur.
REQ-029 Reset asserted mid-operation SHALL clear the state immediately, without waiting for clk_i.

Configuration
REQ-030 Macro CLKRECV_GLITCH_EN: when defined, MIN_HALF checking and glitch_o SHALL behave as in REQ-022.
REQ-031 When CLKRECV_GLITCH_EN is undefined, glitch_o SHALL be tied to 0 and every ACTIVE measurement SHALL update half_period_o.

Verification (defaults; CLKRECV_GLITCH_EN defined unless noted)
REQ-032 sclk_i idles 1, then toggles every 4 clk_i cycles for 3 periods -> first fall_o 3 cycles after the first sample; active_o=1; half_period_o=4; glitch_o never asserted.
REQ-033 While active, a 2-cycle low pulse is applied -> glitch_o pulses once, together with rise_o; half_period_o holds 4.
REQ-034 sclk_i is held at 1 after the last edge -> timeout_o pulses 64 cycles after the last edge pulse; active_o falls in that cycle; half_period_o is unchanged.
REQ-035 The next edge arrives exactly 64 cycles after the previous edge pulse -> no timeout_o; half_period_o=64; active_o stays 1.
REQ-036 rst_ni is pulsed low mid-burst -> all outputs read 0 asynchronously; after release with sclk_i=1, no rise_o occurs; the next fall_o enters ACTIVE.
REQ-037 With CLKRECV_GLITCH_EN undefined, the scenario of REQ-033 is repeated -> glitch_o stays 0 and half_period_o=2.
